// File: rtl/afisaj_7seg_mux.sv
// Four-digit common-anode 7-segment scanner for the stopwatch: per-frame input
// snapshot, leading-minute blanking, minutes/seconds dot and pause blinking.
module afisaj_7seg_mux #(
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 8,
  parameter int BLANK_LEAD   = 1
) (
  input  logic       clk_out,
  input  logic       reset,
  input  logic [3:0] MIN_BCD1,
  input  logic [3:0] MIN_BCD0,
  input  logic [3:0] SEC_BCD1,
  input  logic [3:0] SEC_BCD0,
  input  logic       pauza,
  output logic [3:0] anod,
  output logic [6:0] catod,
  output logic       dp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
  } snap_t;

  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          blink_on_q, blink_on_d;
  snap_t         snap_q, snap_d;
  logic [3:0]    anod_q, anod_d;
  logic [6:0]    catod_q, catod_d;
  logic          dp_q, dp_d;

  logic          slot_end, frame_start, frame_end, lit;
  logic [3:0]    digit;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b0111111;
    endcase
  endfunction

  assign slot_end    = (pre_q == PW'(SCAN_DIV - 1));
  assign frame_start = (pre_q == '0) && (idx_q == 2'd0);
  assign frame_end   = slot_end && (idx_q == 2'd3);

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    pre_d      = slot_end ? '0 : pre_q + 1'b1;
    idx_d      = slot_end ? idx_q + 2'd1 : idx_q;
    snap_d     = frame_start ? snap_t'{MIN_BCD1, MIN_BCD0, SEC_BCD1, SEC_BCD0} : snap_q;
    fcnt_d     = fcnt_q;
    blink_on_d = blink_on_q;
    if (!pauza) begin
      fcnt_d     = '0;
      blink_on_d = 1'b1;
    end else if (frame_end) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d     = '0;
        blink_on_d = ~blink_on_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Decode from the snapshot being latched so digit 0 never shows a stale frame.
  always_comb begin
    digit = snap_d.sec0;
    case (idx_q)
      2'd0: digit = snap_d.sec0;
      2'd1: digit = snap_d.sec1;
      2'd2: digit = snap_d.min0;
      2'd3: digit = snap_d.min1;
      default: digit = snap_d.sec0;
    endcase
    lit = blink_on_q &&
          !((BLANK_LEAD != 0) && (idx_q == 2'd3) && (snap_d.min1 == 4'd0));
    anod_d  = 4'b1111;
    catod_d = 7'h7F;
    dp_d    = 1'b1;
    if (lit) begin
      anod_d  = ~(4'b0001 << idx_q);
      catod_d = seg7(digit);
      dp_d    = (idx_q != 2'd2);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the snapshot is
  // a handful of flops, so it is reset along with everything else.
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      pre_q      <= '0;
      idx_q      <= 2'd0;
      fcnt_q     <= '0;
      blink_on_q <= 1'b1;
      snap_q     <= '0;
      anod_q     <= 4'b1111;
      catod_q    <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      fcnt_q     <= fcnt_d;
      blink_on_q <= blink_on_d;
      snap_q     <= snap_d;
      anod_q     <= anod_d;
      catod_q    <= catod_d;
      dp_q       <= dp_d;
    end
  end

  assign anod  = anod_q;
  assign catod = catod_q;
  assign dp    = dp_q;

endmodule
